apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_cmd_master.sv | 96 +++++++++
 tb/tb_apb_cmd_master.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/apb_cmd_master.sv
// apb_cmd_master: turns one command at a time into an APB transfer and returns a response.
// Ports:
//   clk, reset                      clock and synchronous active-high reset
//   cmd_valid/cmd_ready             command handshake; cmd_write, cmd_addr, cmd_wdata describe it
//   rsp_valid/rsp_ready             response handshake; rsp_rdata, rsp_err, rsp_timeout carry it
//   sel, enable, write, addr, wdata APB request (PSEL, PENABLE, PWRITE, PADDR, PWDATA)
//   rdata, ready, slverr            APB slave response (PRDATA, PREADY, PSLVERR)
module apb_cmd_master #(
    parameter int addrWidth     = 2,
    parameter int dataWidth     = 8,
    parameter int timeoutCycles = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_write,
    input  logic [addrWidth-1:0] cmd_addr,
    input  logic [dataWidth-1:0] cmd_wdata,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [dataWidth-1:0] rsp_rdata,
    output logic                 rsp_err,
    output logic                 rsp_timeout,
    output logic                 sel,
    output logic                 enable,
    output logic                 write,
    output logic [addrWidth-1:0] addr,
    output logic [dataWidth-1:0] wdata,
    input  logic [dataWidth-1:0] rdata,
    input  logic                 ready,
    input  logic                 slverr
);
    localparam int CW = timeoutCycles > 1 ? $clog2(timeoutCycles) : 1;
    localparam logic [CW-1:0] LAST = CW'(timeoutCycles - 1);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t        state, state_next;
    logic [CW-1:0] wait_cnt;
    logic          expired;

    always_ff @(posedge clk) begin
        state <= reset ? IDLE : state_next;
    end

    always_comb begin
        state_next = state;
        cmd_ready  = state == IDLE;
        sel        = state == SETUP || state == ACCESS;
        enable     = state == ACCESS;
        rsp_valid  = state == RESP;
        // ready on the final wait cycle still completes normally
        expired    = !ready && wait_cnt == LAST;
        case (state)
            IDLE:    state_next = cmd_valid ? SETUP : IDLE;
            SETUP:   state_next = ACCESS;
            ACCESS:  state_next = (ready || expired) ? RESP : ACCESS;
            RESP:    state_next = rsp_ready ? IDLE : RESP;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            write       <= 1'b0;
            addr        <= '0;
            wdata       <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            if (state == IDLE && cmd_valid) begin
                write <= cmd_write;
                addr  <= cmd_addr;
                wdata <= cmd_wdata;
            end
            if (state == SETUP)
                wait_cnt <= '0;
            if (state == ACCESS) begin
                if (ready) begin
                    rsp_rdata   <= write ? '0 : rdata;
                    rsp_err     <= slverr;
                    rsp_timeout <= 1'b0;
                end else if (expired) begin
                    rsp_rdata   <= '0;
                    rsp_err     <= 1'b1;
                    rsp_timeout <= 1'b1;
                end else begin
                    wait_cnt <= wait_cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_apb_cmd_master.sv
// tb_apb_cmd_master: directed vector table plus handshake-stall and mid-transfer reset sequences.
module tb_apb_cmd_master;
    logic       clk = 1'b0;
    logic       reset, cmd_valid, cmd_write, rsp_ready, ready, slverr;
    logic [1:0] cmd_addr, addr;
    logic [7:0] cmd_wdata, rsp_rdata, wdata, rdata;
    logic       cmd_ready, rsp_valid, rsp_err, rsp_timeout, sel, enable, write;
    int         passed = 0;
    int         total = 0;

    typedef struct {
        logic       w;
        logic [1:0] a;
        logic [7:0] d;
        int         ready_at;
        logic [7:0] rd;
        logic       se;
        logic [7:0] e_rd;
        logic       e_err;
        logic       e_to;
        int         e_acc;
    } vec_t;

    vec_t vecs[6];

    always #5 clk = ~clk;

    apb_cmd_master dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .sel(sel), .enable(enable),
        .write(write), .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .slverr(slverr)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic run(input vec_t v, input int idx);
        string tag;
        int    acc;
        int    cyc;
        logic  stable;
        tag = $sformatf("v%0d", idx);
        chk({tag, " idle cmd_ready"}, 32'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_write = v.w;
        cmd_addr  = v.a;
        cmd_wdata = v.d;
        rsp_ready = 1'b1;
        ready     = 1'b0;
        step();
        cyc = 1;
        cmd_valid = 1'b0;
        cmd_write = ~v.w;
        cmd_addr  = ~v.a;
        cmd_wdata = ~v.d;
        chk({tag, " setup sel/enable"}, 32'({sel, enable}), 32'b10);
        chk({tag, " setup write/addr/wdata"}, 32'({write, addr, wdata}), 32'({v.w, v.a, v.d}));
        step();
        cyc++;
        acc = 0;
        stable = 1'b1;
        while (sel && enable && acc < 40) begin
            acc++;
            if ({write, addr, wdata} !== {v.w, v.a, v.d}) stable = 1'b0;
            ready  = (acc == v.ready_at);
            rdata  = v.rd;
            slverr = v.se;
            step();
            cyc++;
        end
        ready  = 1'b0;
        rdata  = 8'h5A;
        slverr = 1'b1;
        chk({tag, " access cycles"}, 32'(acc), 32'(v.e_acc));
        chk({tag, " request stable"}, 32'(stable), 1);
        chk({tag, " resp valid/sel/enable"}, 32'({rsp_valid, sel, enable}), 32'b100);
        chk({tag, " rsp_rdata"}, 32'(rsp_rdata), 32'(v.e_rd));
        chk({tag, " rsp_err"}, 32'(rsp_err), 32'(v.e_err));
        chk({tag, " rsp_timeout"}, 32'(rsp_timeout), 32'(v.e_to));
        step();
        cyc++;
        chk({tag, " back to idle"}, 32'({cmd_ready, rsp_valid}), 32'b10);
        chk({tag, " cycles per command"}, 32'(cyc), 32'(v.e_acc + 3));
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'd1, 8'h05, 3,  8'hFF, 1'b0, 8'h00, 1'b0, 1'b0, 3};
        vecs[1] = '{1'b0, 2'd2, 8'h00, 1,  8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0, 1};
        vecs[2] = '{1'b1, 2'd2, 8'h3C, 1,  8'h77, 1'b1, 8'h00, 1'b1, 1'b0, 1};
        vecs[3] = '{1'b0, 2'd3, 8'h00, 0,  8'h99, 1'b0, 8'h00, 1'b1, 1'b1, 16};
        vecs[4] = '{1'b0, 2'd0, 8'h00, 16, 8'h42, 1'b0, 8'h42, 1'b0, 1'b0, 16};
        vecs[5] = '{1'b0, 2'd1, 8'h00, 2,  8'h81, 1'b1, 8'h81, 1'b1, 1'b0, 2};

        reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; ready = 1'b0; slverr = 1'b0; rdata = '0;
        step();
        step();
        chk("reset apb outputs", 32'({sel, enable, write, addr, wdata}), 0);
        chk("reset rsp outputs", 32'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}), 0);
        reset = 1'b0;
        step();
        chk("reset release cmd_ready", 32'(cmd_ready), 1);

        for (int i = 0; i < 6; i++) run(vecs[i], i);

        // response stalled by rsp_ready=0 while a new command waits
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd2; rsp_ready = 1'b0;
        step();
        cmd_valid = 1'b0;
        step();
        ready = 1'b1; rdata = 8'h3C; slverr = 1'b0;
        step();
        ready = 1'b0; rdata = 8'h00; slverr = 1'b1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd1; cmd_wdata = 8'hE7;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall hold %0d", i), 32'({rsp_valid, cmd_ready, rsp_rdata, rsp_err, rsp_timeout, sel}),
                32'({1'b1, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b0}));
            step();
        end
        rsp_ready = 1'b1;
        chk("stall still resp", 32'({rsp_valid, cmd_ready}), 32'b10);
        step();
        chk("stall released idle", 32'({cmd_ready, rsp_valid, sel}), 32'b100);
        step();
        chk("stall next setup", 32'({sel, enable, write, addr, wdata}), 32'({1'b1, 1'b0, 1'b1, 2'd1, 8'hE7}));
        cmd_valid = 1'b0;
        step();
        ready = 1'b1; slverr = 1'b0; rdata = 8'hC3;
        step();
        ready = 1'b0;
        chk("stall next resp", 32'({rsp_valid, rsp_rdata, rsp_err, rsp_timeout}), 32'({1'b1, 8'h00, 1'b0, 1'b0}));
        step();

        // reset in the middle of ACCESS drops the transfer
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd3;
        step();
        cmd_valid = 1'b0;
        step();
        chk("abort in access", 32'({sel, enable}), 32'b11);
        reset = 1'b1;
        step();
        chk("abort outputs", 32'({sel, enable, rsp_valid, cmd_ready}), 32'b0001);
        chk("abort request cleared", 32'({write, addr, wdata}), 0);
        reset = 1'b0; ready = 1'b1; rdata = 8'hEE;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("abort no response %0d", i), 32'({rsp_valid, sel, cmd_ready}), 32'b001);
        end
        ready = 1'b0;

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
